// File: rtl/traffic_light_actuated_fsm.sv
// Actuated two-way intersection controller: NS/EW greens with min/max limits,
// latched pedestrian walk phase, all-red clearance and a night flashing-yellow mode.
module traffic_light_actuated_fsm #(
   parameter int unsigned GREEN_TIME   = 5,
   parameter int unsigned MIN_GREEN    = 2,
   parameter int unsigned YELLOW_TIME  = 2,
   parameter int unsigned ALL_RED_TIME = 1,
   parameter int unsigned PED_TIME     = 3,
   parameter int unsigned FLASH_HALF   = 2,
   parameter int unsigned CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ns_car,
   input  logic       ew_car,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       ped_walk,
   output logic       ped_pending,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_NS_G    = 3'd0,
      S_NS_Y    = 3'd1,
      S_ALL_RED = 3'd2,
      S_EW_G    = 3'd3,
      S_EW_Y    = 3'd4,
      S_PED     = 3'd5,
      S_FLASH   = 3'd6
   } state_t;

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
   localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(ALL_RED_TIME - 1);
   localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_TIME - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);

   // Lamp vector layout: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk}
   localparam logic [6:0] LAMPS_RESET = 7'b001_100_0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             next_dir_q, next_dir_d;
   logic             ped_pending_q, ped_pending_d;
   logic             flash_q, flash_d;
   logic [6:0]       lamps_q;

   function automatic logic [6:0] decode_lamps(input state_t s, input logic f);
      logic [6:0] l;
      case (s)
         S_NS_G:    l = 7'b001_100_0;
         S_NS_Y:    l = 7'b010_100_0;
         S_ALL_RED: l = 7'b100_100_0;
         S_EW_G:    l = 7'b100_001_0;
         S_EW_Y:    l = 7'b100_010_0;
         S_PED:     l = 7'b100_100_1;
         S_FLASH:   l = {1'b0, f, 1'b0, 1'b0, f, 1'b0, 1'b0};
         default:   l = 7'b100_100_0;
      endcase
      return l;
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + 1'b1;
      next_dir_d    = next_dir_q;
      flash_d       = flash_q;
      ped_pending_d = ped_pending_q | ped_req;

      case (state_q)
         S_NS_G: begin
            // Yield only after min green, and before max-out only if own approach is empty.
            if ((cnt_q >= MIN_LAST) && (ew_car || ped_pending_q) &&
                (!ns_car || (cnt_q >= GREEN_LAST))) begin
               state_d = S_NS_Y;
               cnt_d   = '0;
            end else if (cnt_q >= GREEN_LAST) begin
               cnt_d = GREEN_LAST;
            end
         end

         S_EW_G: begin
            if ((cnt_q >= MIN_LAST) && (ns_car || ped_pending_q) &&
                (!ew_car || (cnt_q >= GREEN_LAST))) begin
               state_d = S_EW_Y;
               cnt_d   = '0;
            end else if (cnt_q >= GREEN_LAST) begin
               cnt_d = GREEN_LAST;
            end
         end

         S_NS_Y: begin
            if (cnt_q == YELLOW_LAST) begin
               state_d    = S_ALL_RED;
               cnt_d      = '0;
               next_dir_d = DIR_EW;
            end
         end

         S_EW_Y: begin
            if (cnt_q == YELLOW_LAST) begin
               state_d    = S_ALL_RED;
               cnt_d      = '0;
               next_dir_d = DIR_NS;
            end
         end

         S_ALL_RED: begin
            if (cnt_q == AR_LAST) begin
               cnt_d = '0;
               if (night_mode) begin
                  state_d = S_FLASH;
                  flash_d = 1'b1;
               end else if (ped_pending_q) begin
                  state_d       = S_PED;
                  ped_pending_d = ped_req;
               end else begin
                  state_d = (next_dir_q == DIR_EW) ? S_EW_G : S_NS_G;
               end
            end
         end

         S_PED: begin
            if (cnt_q == PED_LAST) begin
               state_d = (next_dir_q == DIR_EW) ? S_EW_G : S_NS_G;
               cnt_d   = '0;
            end
         end

         S_FLASH: begin
            if (!night_mode) begin
               state_d    = S_ALL_RED;
               cnt_d      = '0;
               next_dir_d = DIR_NS;
            end else if (cnt_q == FLASH_LAST) begin
               cnt_d   = '0;
               flash_d = ~flash_q;
            end
         end

         default: begin
            state_d = S_NS_G;
            cnt_d   = '0;
         end
      endcase
   end

   // Lamps are registered from the next state so they always match state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_NS_G;
         cnt_q         <= '0;
         next_dir_q    <= DIR_EW;
         ped_pending_q <= 1'b0;
         flash_q       <= 1'b1;
         lamps_q       <= LAMPS_RESET;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         next_dir_q    <= next_dir_d;
         ped_pending_q <= ped_pending_d;
         flash_q       <= flash_d;
         lamps_q       <= decode_lamps(state_d, flash_d);
      end
   end

   assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk} = lamps_q;
   assign ped_pending = ped_pending_q;
   assign phase       = state_q;

endmodule

// File: tb/tb_traffic_light_actuated_fsm.sv
// Directed bench for traffic_light_actuated_fsm: per-scenario tasks with
// hand-computed phase/lamp sequences plus a per-cycle safety monitor.
module tb_traffic_light_actuated_fsm;

   logic       clk;
   logic       rst;
   logic       ns_car, ew_car, ped_req, night_mode;
   logic       ns_red, ns_yellow, ns_green;
   logic       ew_red, ew_yellow, ew_green;
   logic       ped_walk, ped_pending;
   logic [2:0] phase;
   logic [6:0] lamps;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   traffic_light_actuated_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .ns_car     (ns_car),
      .ew_car     (ew_car),
      .ped_req    (ped_req),
      .night_mode (night_mode),
      .ns_red     (ns_red),
      .ns_yellow  (ns_yellow),
      .ns_green   (ns_green),
      .ew_red     (ew_red),
      .ew_yellow  (ew_yellow),
      .ew_green   (ew_green),
      .ped_walk   (ped_walk),
      .ped_pending(ped_pending),
      .phase      (phase)
   );

   assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   // Expected lamps {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for non-flash phases.
   function automatic logic [6:0] lamps_for(input int p);
      case (p)
         0:       return 7'b0011000;
         1:       return 7'b0101000;
         2:       return 7'b1001000;
         3:       return 7'b1000010;
         4:       return 7'b1000100;
         5:       return 7'b1001001;
         default: return 7'b0000000;
      endcase
   endfunction

   // Safety monitor
   always @(negedge clk) begin
      if (mon_en) begin
         logic ns_nr, ew_nr, v_cross, v_walk, v_multi;
         ns_nr   = ns_yellow | ns_green;
         ew_nr   = ew_yellow | ew_green;
         v_cross = ns_nr && ew_nr && !((phase == 3'd6) && !ns_green && !ew_green);
         v_walk  = ped_walk && (phase != 3'd5);
         v_multi = ($countones({ns_red, ns_yellow, ns_green}) > 1) ||
                   ($countones({ew_red, ew_yellow, ew_green}) > 1);
         total++;
         if (v_cross || v_walk || v_multi) begin
            bad++;
            $display("FAIL safety: phase=%0d lamps=%b expected no conflict", phase, lamps);
         end
      end
   end

   task automatic test_reset();
      ns_car = 1'b1; ew_car = 1'b1; ped_req = 1'b1; night_mode = 1'b1;
      apply_reset(2);
      mon_en = 1'b1;
      total++;
      if ({phase, lamps, ped_pending} !== {3'd0, 7'b0011000, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: got ph=%0d lamps=%b pend=%b expected ph=0 lamps=0011000 pend=0",
                  phase, lamps, ped_pending);
      end
   endtask

   task automatic test_rest_in_ew();
      int exp_ph[$];
      ns_car = 1'b0; ew_car = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
      apply_reset(2);
      exp_ph = '{0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      foreach (exp_ph[i]) begin
         if (i > 0) step();
         total++;
         if ({phase, lamps} !== {3'(exp_ph[i]), lamps_for(exp_ph[i])}) begin
            bad++;
            $display("FAIL rest_ew[%0d]: got ph=%0d lamps=%b expected ph=%0d lamps=%b",
                     i, phase, lamps, exp_ph[i], lamps_for(exp_ph[i]));
         end
      end
   endtask

   task automatic test_full_cycle();
      int period[$];
      ns_car = 1'b1; ew_car = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
      apply_reset(2);
      period = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 2};
      for (int i = 0; i < 32; i++) begin
         if (i > 0) step();
         total++;
         if ({phase, lamps} !== {3'(period[i % 16]), lamps_for(period[i % 16])}) begin
            bad++;
            $display("FAIL full_cycle[%0d]: got ph=%0d lamps=%b expected ph=%0d lamps=%b",
                     i, phase, lamps, period[i % 16], lamps_for(period[i % 16]));
         end
      end
   endtask

   task automatic test_idle();
      ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
      apply_reset(2);
      for (int i = 0; i < 50; i++) begin
         step();
         total++;
         if ({phase, ns_green, ew_red, ped_walk} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL idle[%0d]: got ph=%0d ns_g=%b ew_r=%b walk=%b expected ph=0 1 1 0",
                     i, phase, ns_green, ew_red, ped_walk);
         end
      end
   endtask

   task automatic test_ped(input bit cross_car);
      int exp_ph[$];
      int exp_pd[$];
      ns_car = 1'b1; ew_car = cross_car; ped_req = 1'b0; night_mode = 1'b0;
      apply_reset(2);
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      exp_ph = '{0, 0, 0, 0, 1, 1, 2, 5, 5, 5, 3, 3};
      exp_pd = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      foreach (exp_ph[i]) begin
         if (i > 0) step();
         total++;
         if ({phase, lamps, ped_pending} !==
             {3'(exp_ph[i]), lamps_for(exp_ph[i]), 1'(exp_pd[i])}) begin
            bad++;
            $display("FAIL ped(car=%0d)[%0d]: got ph=%0d lamps=%b pend=%b expected ph=%0d lamps=%b pend=%0d",
                     cross_car, i, phase, lamps, ped_pending, exp_ph[i], lamps_for(exp_ph[i]), exp_pd[i]);
         end
      end
   endtask

   task automatic test_night();
      int         exp_ph[$];
      logic [6:0] exp_lm[$];
      ns_car = 1'b0; ew_car = 1'b1; ped_req = 1'b0; night_mode = 1'b1;
      apply_reset(2);
      exp_ph = '{0, 0, 1, 1, 2, 6, 6, 6, 6, 6, 6};
      exp_lm = '{7'b0011000, 7'b0011000, 7'b0101000, 7'b0101000, 7'b1001000,
                 7'b0100100, 7'b0100100, 7'b0000000, 7'b0000000, 7'b0100100, 7'b0100100};
      foreach (exp_ph[i]) begin
         if (i > 0) step();
         total++;
         if ({phase, lamps} !== {3'(exp_ph[i]), exp_lm[i]}) begin
            bad++;
            $display("FAIL night[%0d]: got ph=%0d lamps=%b expected ph=%0d lamps=%b",
                     i, phase, lamps, exp_ph[i], exp_lm[i]);
         end
      end
      night_mode = 1'b0;
      step();
      total++;
      if ({phase, lamps} !== {3'd2, 7'b1001000}) begin
         bad++;
         $display("FAIL night_exit_ar: got ph=%0d lamps=%b expected ph=2 lamps=1001000", phase, lamps);
      end
      step();
      total++;
      if ({phase, lamps} !== {3'd0, 7'b0011000}) begin
         bad++;
         $display("FAIL night_exit_nsg: got ph=%0d lamps=%b expected ph=0 lamps=0011000", phase, lamps);
      end
   endtask

   task automatic test_reset_mid_ew_y();
      ns_car = 1'b0; ew_car = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
      apply_reset(2);
      repeat (5) step();
      total++;
      if (phase !== 3'd3) begin
         bad++;
         $display("FAIL mid_reset_ewg: got ph=%0d expected ph=3", phase);
      end
      ped_req = 1'b1; ew_car = 1'b0;
      step();
      ped_req = 1'b0;
      step();
      total++;
      if ({phase, ped_pending} !== {3'd4, 1'b1}) begin
         bad++;
         $display("FAIL mid_reset_ewy: got ph=%0d pend=%b expected ph=4 pend=1", phase, ped_pending);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if ({phase, lamps, ped_pending} !== {3'd0, 7'b0011000, 1'b0}) begin
         bad++;
         $display("FAIL mid_reset_after: got ph=%0d lamps=%b pend=%b expected ph=0 lamps=0011000 pend=0",
                  phase, lamps, ped_pending);
      end
   endtask

   initial begin
      rst = 1'b1;
      ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
      test_reset();
      test_rest_in_ew();
      test_full_cycle();
      test_idle();
      test_ped(1'b0);
      test_ped(1'b1);
      test_night();
      test_reset_mid_ew_y();
      step();
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_light_actuated_fsm.md
Name: traffic_light_actuated_fsm

Overview:
Second-generation two-way intersection controller (NS/EW) with fully parametrised phase timing. Over the fixed-time controller it adds vehicle-actuated greens with min/max limits and rest-in-green, a latched pedestrian walk phase, an all-red clearance interval, and a night flashing-yellow mode. Drives lamp outputs directly; one instance per intersection.

Parameters:
GREEN_TIME, 5, max green cycles per direction (max-out)
MIN_GREEN, 2, min green cycles before yielding; 1 <= MIN_GREEN <= GREEN_TIME
YELLOW_TIME, 2, yellow cycles
ALL_RED_TIME, 1, all-red clearance cycles
PED_TIME, 3, walk cycles
FLASH_HALF, 2, cycles per half-period of night flash
CNT_W, 8, phase counter width; every *_TIME parameter must be >= 1 and < 2**CNT_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ns_car  in  1  NS vehicle present (level)
ew_car  in  1  EW vehicle present (level)
ped_req  in  1  pedestrian button; single-cycle pulse or level
night_mode  in  1  request flashing mode (level)
ns_red, ns_yellow, ns_green  out  1 each  NS lamps
ew_red, ew_yellow, ew_green  out  1 each  EW lamps
ped_walk  out  1  walk signal
ped_pending  out  1  latched pedestrian request
phase  out  3  state code: NS_G=0 NS_Y=1 ALL_RED=2 EW_G=3 EW_Y=4 PED=5 FLASH=6

Behaviour:
- Clocking: single clock domain; rst is synchronous, active-high, and overrides all other inputs.
- Moore outputs decoded from the state register only; no input-to-output combinational paths.
- Reset (any state, any cycle): state=NS_G, cnt=0, next_dir=EW, ped_pending=0, flash phase=on. Outputs during/after reset: ns_green=1, ew_red=1, all other lamps 0, ped_walk=0.
- cnt resets to 0 on every state entry and increments by 1 each cycle. A state of duration T lasts exactly T cycles: exit when cnt==T-1.
- ped_pending: set on any cycle with ped_req=1, cleared on PED entry; set has priority over clear in the same cycle.
- NS_G (EW_G symmetric; swap car inputs): own lamps green, cross red.
  - cross_demand = ew_car | ped_pending.
  - Exit to NS_Y when cnt >= MIN_GREEN-1 AND cross_demand AND (ns_car==0 OR cnt >= GREEN_TIME-1).
  - With no cross_demand: rest in green; cnt saturates at GREEN_TIME-1.
- NS_Y: ns_yellow=1, ew_red=1; lasts YELLOW_TIME, then ALL_RED with next_dir=EW. EW_Y mirrors with next_dir=NS.
- ALL_RED: both reds on; lasts ALL_RED_TIME. Exit priority evaluated on the final cycle:
  - night_mode=1 -> FLASH
  - else ped_pending=1 -> PED
  - else -> green of next_dir
- PED: both reds on, ped_walk=1; lasts PED_TIME, then green of next_dir.
- FLASH: reds 0, greens 0. ns_yellow=ew_yellow=flash bit. Flash bit is 1 on entry and toggles every FLASH_HALF cycles. ped_walk=0; ped_pending still latches. On night_mode=0 -> ALL_RED with next_dir=NS.
- Safety invariants (must never occur):
  - any NS lamp other than red active while any EW lamp other than red is active (FLASH excepted: both yellows only)
  - ped_walk=1 outside PED
  - more than one lamp lit per direction
- night_mode asserted during a green/yellow takes effect only at the next ALL_RED exit; it never truncates a yellow or all-red interval.
- Simultaneous ped_req and cross car: single exit; PED runs before the cross green.

Test Plan:
1. rst 2 cycles, ns_car=0, ew_car=1, others 0 -> NS_G 2 cycles, NS_Y 2, ALL_RED 1, EW_G rests indefinitely (ns_car=0); ew_green=1, ns_red=1.
2. ns_car=ew_car=1 constant -> repeating 16-cycle cycle: NS_G 5, NS_Y 2, ALL_RED 1, EW_G 5, EW_Y 2, ALL_RED 1.
3. All inputs 0 for 50 cycles after reset -> phase stays 0, ns_green=1, ew_red=1, ped_walk=0.
4. ns_car=1, ew_car=0, 1-cycle ped_req at cnt=0 of NS_G -> ped_pending=1; NS_G 5, NS_Y 2, ALL_RED 1, PED 3 (ped_walk=1, all reds, ped_pending=0), then EW_G.
5. night_mode=1 during NS_G with ew_car=1 -> normal NS_Y/ALL_RED, then FLASH: yellows 1,1,0,0,... reds 0. Drop night_mode -> ALL_RED 1 cycle -> NS_G.
6. rst pulsed 1 cycle mid EW_Y with ped_pending=1 -> next edge phase=0, ns_green=1, ped_pending=0. Safety invariants checked every cycle across all scenarios.
